// File: rtl/ibex_cheri_tag_pkg.sv
// Shared types for the CHERI tag-memory controller: FSM states, port winner, index width.
package ibex_cheri_tag_pkg;

  localparam int unsigned TAG_IDX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } tag_ctrl_state_e;

  typedef enum logic [1:0] {
    NONE,
    LSU,
    CLR
  } tag_winner_e;

endpackage

// File: rtl/ibex_cheri_tag_clr_seq.sv
// Bulk tag-clear sequencer: walks ptr from base to last, one step per granted cycle,
// then raises a single-cycle done pulse.
module ibex_cheri_tag_clr_seq
  import ibex_cheri_tag_pkg::*;
#(
  parameter int unsigned TAG_MEM_SIZE = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_start_i,
  input  logic [TAG_IDX_W-1:0] clr_base_i,
  input  logic [TAG_IDX_W-1:0] clr_len_i,
  input  logic                 advance_i,
  output logic                 clr_pending_o,
  output logic [TAG_IDX_W-1:0] clr_addr_o,
  output logic                 clr_busy_o,
  output logic                 clr_done_o
);

  localparam logic [TAG_IDX_W-1:0] SIZE_W  = TAG_IDX_W'(TAG_MEM_SIZE);
  localparam logic [TAG_IDX_W:0]   SIZE_W1 = (TAG_IDX_W+1)'(TAG_MEM_SIZE);

  tag_ctrl_state_e      r_state, w_state_nxt;
  logic [TAG_IDX_W-1:0] r_ptr, r_last;
  logic [TAG_IDX_W:0]   w_end;
  logic [TAG_IDX_W-1:0] w_last;
  logic                 w_start_ok;

  // End index is formed one bit wider so base+len can never wrap.
  assign w_end      = {1'b0, clr_base_i} + {1'b0, clr_len_i};
  assign w_last     = (w_end > SIZE_W1) ? (SIZE_W - TAG_IDX_W'(1))
                                        : TAG_IDX_W'(w_end - (TAG_IDX_W+1)'(1));
  assign w_start_ok = (clr_len_i != '0) && (clr_base_i < SIZE_W);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (clr_start_i) w_state_nxt = w_start_ok ? CLEAR : DONE;
      CLEAR:   if (advance_i && (r_ptr == r_last)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_pending_o = (r_state == CLEAR);
    clr_busy_o    = (r_state == CLEAR) || (r_state == DONE);
    clr_done_o    = (r_state == DONE);
    clr_addr_o    = r_ptr;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr  <= '0;
      r_last <= '0;
    end else if ((r_state == IDLE) && clr_start_i && w_start_ok) begin
      r_ptr  <= clr_base_i;
      r_last <= w_last;
    end else if ((r_state == CLEAR) && advance_i) begin
      r_ptr  <= r_ptr + TAG_IDX_W'(1);
    end
  end

endmodule

// File: rtl/ibex_cheri_tag_ctrl.sv
// Tag-memory port arbiter between the LSU and the bulk clear engine, with range
// checking, a bounded-starvation stall counter and one-cycle LSU responses.
module ibex_cheri_tag_ctrl
  import ibex_cheri_tag_pkg::*;
#(
  parameter int unsigned TAG_MEM_SIZE  = 4096,
  parameter int unsigned CLR_MAX_STALL = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [TAG_IDX_W-1:0] lsu_addr_i,
  input  logic                 lsu_wdata_i,
  output logic                 lsu_gnt_o,
  output logic                 lsu_rvalid_o,
  output logic                 lsu_rdata_o,
  output logic                 lsu_err_o,
  input  logic                 clr_start_i,
  input  logic [TAG_IDX_W-1:0] clr_base_i,
  input  logic [TAG_IDX_W-1:0] clr_len_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic [TAG_IDX_W-1:0] tag_addr_o,
  output logic                 tag_we_o,
  output logic                 tag_wdata_o,
  input  logic                 tag_rdata_i
);

  localparam int unsigned        STALL_W   = $clog2(CLR_MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(CLR_MAX_STALL);

  tag_winner_e          w_winner;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 w_clr_pending, w_lsu_in_range;
  logic [TAG_IDX_W-1:0] w_clr_addr;
  logic                 r_rvalid, r_err, r_rd;

  ibex_cheri_tag_clr_seq #(
    .TAG_MEM_SIZE(TAG_MEM_SIZE)
  ) u_clr_seq (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_start_i  (clr_start_i),
    .clr_base_i   (clr_base_i),
    .clr_len_i    (clr_len_i),
    .advance_i    (w_winner == CLR),
    .clr_pending_o(w_clr_pending),
    .clr_addr_o   (w_clr_addr),
    .clr_busy_o   (clr_busy_o),
    .clr_done_o   (clr_done_o)
  );

  assign w_lsu_in_range = lsu_addr_i < TAG_IDX_W'(TAG_MEM_SIZE);

  // Nothing owns the port while reset is held, so no grant can lose its response.
  always_comb begin
    w_winner = NONE;
    if (!rst_ni)            w_winner = NONE;
    else if (w_clr_pending) w_winner = (lsu_req_i && (r_stall_cnt != STALL_MAX)) ? LSU : CLR;
    else if (lsu_req_i)     w_winner = LSU;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                           r_stall_cnt <= '0;
    else if (w_clr_pending && w_winner == LSU) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    else                                   r_stall_cnt <= '0;
  end

  always_comb begin
    tag_addr_o  = '0;
    tag_we_o    = 1'b0;
    tag_wdata_o = 1'b0;
    case (w_winner)
      LSU: if (w_lsu_in_range) begin
        tag_addr_o  = lsu_addr_i;
        tag_we_o    = lsu_we_i;
        tag_wdata_o = lsu_wdata_i;
      end
      CLR: begin
        tag_addr_o = w_clr_addr;
        tag_we_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign lsu_gnt_o = (w_winner == LSU);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_rvalid <= lsu_gnt_o;
      r_err    <= lsu_gnt_o & ~w_lsu_in_range;
      r_rd     <= lsu_gnt_o & ~lsu_we_i & w_lsu_in_range;
    end
  end

  assign lsu_rvalid_o = r_rvalid;
  assign lsu_err_o    = r_err;
  assign lsu_rdata_o  = r_rd & tag_rdata_i;

endmodule

// File: doc/ibex_cheri_tag_ctrl.md
# ibex_cheri_tag_ctrl

Controller and arbiter in front of the single-port CHERI tag memory. Shares the memory port between the core's load/store tag path (LSU) and a bulk tag-clear engine, which zeroes a contiguous range of tags for revocation and allocator reuse. It performs range checking and issues one memory access per cycle. A bounded-starvation rule guarantees forward progress for the clear engine.

## Interface
Parameters:
- TAG_MEM_SIZE, 4096: number of tag bits in the memory; valid indices are 0..TAG_MEM_SIZE-1.
- CLR_MAX_STALL, 4: maximum consecutive cycles a pending clear write loses to the LSU before it is forced through (≥1).

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- lsu_req_i  in  1  LSU tag access request; held until granted.
- lsu_we_i  in  1  1 = write tag, 0 = read tag.
- lsu_addr_i  in  32  tag index (capability-granule index).
- lsu_wdata_i  in  1  tag value to write.
- lsu_gnt_o  out  1  request accepted this cycle (combinational).
- lsu_rvalid_o  out  1  response for the access granted in the previous cycle.
- lsu_rdata_o  out  1  read tag; 0 for writes and out-of-range accesses.
- lsu_err_o  out  1  valid with lsu_rvalid_o; 1 = index ≥ TAG_MEM_SIZE.
- clr_start_i  in  1  start a bulk clear; sampled only in IDLE.
- clr_base_i  in  32  first index to clear.
- clr_len_i  in  32  number of tags to clear.
- clr_busy_o  out  1  clear in progress.
- clr_done_o  out  1  one-cycle pulse when a clear finishes.
- tag_addr_o  out  32  memory index.
- tag_we_o  out  1  memory write enable.
- tag_wdata_o  out  1  memory write data.
- tag_rdata_i  in  1  memory read data, valid one cycle after a non-write access.

## Operation
- FSM states:
  - IDLE → CLEAR on clr_start_i with clr_len_i ≠ 0 and clr_base_i < TAG_MEM_SIZE. Load ptr = clr_base_i and last = min(clr_base_i + clr_len_i, TAG_MEM_SIZE) − 1. Compute the sum in 33 bits, with no wrap.
  - IDLE → DONE on clr_start_i with clr_len_i = 0 or clr_base_i ≥ TAG_MEM_SIZE. No memory writes occur.
  - CLEAR: each cycle the clear side wins the port, it writes 0 at ptr. If ptr = last, go to DONE; otherwise ptr += 1.
  - DONE: clr_done_o = 1 for one cycle, then IDLE.
- clr_start_i is ignored outside IDLE.
- clr_busy_o = 1 in CLEAR and DONE.
- Arbitration, evaluated when the clear side is pending (state CLEAR):
  - With lsu_req_i = 1, the LSU wins and stall_cnt increments.
  - When stall_cnt = CLR_MAX_STALL, the clear side wins, lsu_gnt_o = 0, and stall_cnt resets to 0.
  - stall_cnt resets whenever the clear side wins, and in IDLE.
- When not in CLEAR, the LSU wins every cycle it requests.
- LSU accesses:
  - In range: drive tag_addr_o = lsu_addr_i, tag_we_o = lsu_we_i, tag_wdata_o = lsu_wdata_i.
  - Out of range: drive tag_we_o = 0, still grant, and respond with lsu_err_o = 1 and lsu_rdata_o = 0.
  - Writes are acknowledged through lsu_rvalid_o, with lsu_rdata_o = 0.
- No port winner: tag_we_o = 0 and tag_addr_o = 0.

## Timing
- lsu_gnt_o is combinational from lsu_req_i, state and stall_cnt.
- Response latency is exactly 1 cycle: lsu_rvalid_o rises in the cycle after grant and carries registered we/err flags. lsu_rdata_o comes from tag_rdata_i in that cycle.
- Back-to-back grants are allowed every cycle; there is no response back-pressure.
- A clear of N in-range tags with no LSU traffic takes N cycles in CLEAR, plus 1 DONE cycle.
- Worst case with continuous LSU requests: one clear write per CLR_MAX_STALL+1 cycles.
- Reset:
  - State goes to IDLE and stall_cnt to 0.
  - All outputs go to 0: lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o, clr_busy_o, clr_done_o and tag_*.
  - A clear aborted by reset gives no clr_done_o. Tags already written stay 0; the memory has its own reset.
- An LSU read of an index the clear has not yet reached returns the old tag. There is no ordering guarantee beyond port order.

## Structure
- Package ibex_cheri_tag_pkg holds:
  - the tag_ctrl_state_e enum (IDLE, CLEAR, DONE);
  - TAG_IDX_W = 32;
  - the arbitration winner enum (NONE, LSU, CLR).
- One sub-module, ibex_cheri_tag_clr_seq, contains the FSM, ptr/last registers and done pulse. It exposes clr_pending, clr_addr and an advance input.
- The top level holds the arbiter, stall counter, range check and response registers.

## Test plan
- Reset, then LSU read of index 5, which holds 1: gnt in cycle 0; rvalid = 1, rdata = 1, err = 0 in cycle 1.
- LSU write of index 4096 with TAG_MEM_SIZE = 4096: granted, tag_we_o = 0, rvalid = 1 with err = 1 and rdata = 0.
- Clear base = 10, len = 4 with no LSU traffic: zero writes to 10, 11, 12, 13 on consecutive cycles; clr_done_o in the 5th cycle; a subsequent read of 12 returns 0.
- Clear base = 4094, len = 8: only 4094 and 4095 are written, then done. With len = 0: done pulse one cycle after start, with no writes.
- Clear len = 3 while lsu_req_i is held high continuously (CLR_MAX_STALL = 4): LSU granted 4 cycles, clear 1, repeating; done after 15 clear-state cycles.
- Assert rst_ni = 0 mid-clear at ptr = 12: next cycle busy = 0 and no done pulse; later writes do not continue.
